// File: rtl/buffer_drain_scheduler.sv
// buffer_drain_scheduler
// Read-side scheduler for the four 6-slot packet buffers. Once per read period
// it picks the fullest buffer (round-robin on ties), snapshots its head value,
// runs a req/ack pop handshake with the buffer owner and reports the result.
module buffer_drain_scheduler #(
  parameter int unsigned READ_PERIOD = 150_000_000,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [17:0] buffer1_o,
  input  logic [17:0] buffer2_o,
  input  logic [17:0] buffer3_o,
  input  logic [17:0] buffer4_o,
  input  logic        pop_ack,
  output logic        pop_req,
  output logic [1:0]  pop_sel,
  output logic        read,
  output logic [1:0]  disp,
  output logic [1:0]  data_out,
  output logic [7:0]  missed_cnt,
  output logic        ack_err
);

  localparam int CW = (READ_PERIOD > 2) ? $clog2(READ_PERIOD) : 1;
  localparam int TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(READ_PERIOD - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    REQ  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            pending_q, pending_d;
  logic [1:0]      last_q, last_d;
  logic [1:0]      snap_q, snap_d;
  logic            pop_req_q, pop_req_d;
  logic [1:0]      pop_sel_q, pop_sel_d;
  logic            read_q, read_d;
  logic [1:0]      disp_q, disp_d;
  logic [1:0]      data_q, data_d;
  logic [7:0]      missed_q, missed_d;
  logic            ack_err_q, ack_err_d;

  logic            tick;
  logic [17:0]     bufs [4];
  logic [2:0]      occ  [4];
  logic            any_nonempty;
  logic [1:0]      arb_sel;
  logic [2:0]      best_occ;
  logic [1:0]      idx;
  logic            unused_value_bits;

  assign bufs[0] = buffer1_o;
  assign bufs[1] = buffer2_o;
  assign bufs[2] = buffer3_o;
  assign bufs[3] = buffer4_o;

  // Only the head value and the valid bits matter to the scheduler.
  assign unused_value_bits = ^{buffer1_o[17:3], buffer2_o[17:3], buffer3_o[17:3], buffer4_o[17:3]};

  assign tick = enable && (cnt_q == CNT_MAX);

  // Period counter: free-runs while enabled, parked at zero otherwise.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Occupancy of each buffer is the number of set valid bits across its six slots.
  always_comb begin
    any_nonempty = 1'b0;
    for (int i = 0; i < 4; i++) begin
      occ[i] = 3'd0;
      for (int k = 0; k < 6; k++) begin
        occ[i] = occ[i] + {2'b00, bufs[i][3*k]};
      end
      if (occ[i] != 3'd0) begin
        any_nonempty = 1'b1;
      end
    end
  end

  // Fullest buffer wins; scanning from last+1 with a strict compare gives round-robin ties.
  always_comb begin
    arb_sel  = last_q + 2'd1;
    best_occ = 3'd0;
    idx      = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = last_q + 2'd1 + 2'(k);
      if (occ[idx] > best_occ) begin
        best_occ = occ[idx];
        arb_sel  = idx;
      end
    end
  end

  // Next-state logic for the FSM, tick bookkeeping and all registered outputs.
  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    pending_d = pending_q;
    last_d    = last_q;
    snap_d    = snap_q;
    pop_req_d = pop_req_q;
    pop_sel_d = pop_sel_q;
    read_d    = 1'b0;
    disp_d    = disp_q;
    data_d    = data_q;
    missed_d  = missed_q;
    ack_err_d = ack_err_q;

    if (tick) begin
      if (pending_q) begin
        if (missed_q != 8'hFF) begin
          missed_d = missed_q + 8'd1;
        end
      end else begin
        pending_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (pending_q) begin
          pending_d = 1'b0;
          if (any_nonempty) begin
            state_d = ARB;
          end
        end
      end
      ARB: begin
        pop_sel_d = arb_sel;
        snap_d    = bufs[arb_sel][2:1];
        tmo_d     = '0;
        pop_req_d = 1'b1;
        state_d   = REQ;
      end
      REQ: begin
        if (pop_ack) begin
          pop_req_d = 1'b0;
          read_d    = 1'b1;
          disp_d    = pop_sel_q;
          data_d    = snap_q;
          last_d    = pop_sel_q;
          state_d   = IDLE;
        end else if (tmo_q == TMO_LAST) begin
          pop_req_d = 1'b0;
          ack_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: begin
        pop_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tmo_q     <= '0;
      pending_q <= 1'b0;
      last_q    <= 2'd3;
      snap_q    <= 2'd0;
      pop_req_q <= 1'b0;
      pop_sel_q <= 2'd0;
      read_q    <= 1'b0;
      disp_q    <= 2'd0;
      data_q    <= 2'd0;
      missed_q  <= 8'd0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      pending_q <= pending_d;
      last_q    <= last_d;
      snap_q    <= snap_d;
      pop_req_q <= pop_req_d;
      pop_sel_q <= pop_sel_d;
      read_q    <= read_d;
      disp_q    <= disp_d;
      data_q    <= data_d;
      missed_q  <= missed_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign pop_req    = pop_req_q;
  assign pop_sel    = pop_sel_q;
  assign read       = read_q;
  assign disp       = disp_q;
  assign data_out   = data_q;
  assign missed_cnt = missed_q;
  assign ack_err    = ack_err_q;

endmodule

// File: doc/buffer_drain_scheduler.md
# buffer_drain_scheduler

Read-side scheduler for the four 6-slot packet buffers (blue/green/red/purple columns). Once per read period it picks the buffer to drain (fullest first, round-robin on ties), snapshots that buffer's head entry, and runs a req/ack pop handshake with the buffer owner. It reports the served buffer and value to the display/LED path, and flags missed periods and handshake failures. It sits between the take_in buffer registers and the read/display logic.

## Interface
Parameters:
- READ_PERIOD, 150_000_000: cycles between read ticks (3 s at 50 MHz); must be ≥ 4.
- ACK_TIMEOUT, 16: maximum cycles pop_req may wait for pop_ack.

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- rst  in  1  synchronous, active-high reset
- enable  in  1  run enable (start switch); low holds the period counter at 0
- buffer1_o … buffer4_o  in  18 each  buffer images; slot k (k=0..5) = bits [3k+2:3k], valid = bit 3k, value = bits [3k+2:3k+1]; slot 0 is the head (oldest)
- pop_ack  in  1  buffer owner has shifted the selected buffer
- pop_req  out  1  pop request, level, held until ack or timeout
- pop_sel  out  2  buffer index under request (0 = buffer1 … 3 = buffer4)
- read  out  1  one-cycle pulse: a pop completed
- disp  out  2  index of the last served buffer
- data_out  out  2  head value of the last served buffer
- missed_cnt  out  8  saturating count of ticks dropped while one was already pending
- ack_err  out  1  sticky: a handshake timed out

## Operation
- Period counter: counts 0..READ_PERIOD-1 while enable=1 and wraps. tick = (cnt == READ_PERIOD-1), one cycle wide. enable=0 forces cnt to 0 and produces no ticks.
- pending flag: set by tick, cleared when IDLE consumes it. A tick arriving while pending=1 increments missed_cnt, saturating at 255.
- occ[i] = popcount of the six valid bits of buffer i (0..6). Buffer i is nonempty when occ[i] > 0.
- Arbitration: choose the maximum occ. On ties, search round-robin starting at last+1 mod 4, where last is the previously served index (reset value 3, so the first tie goes to buffer1).
- FSM states:
  - IDLE: if pending, clear pending. If any buffer is nonempty, go to ARB; otherwise the tick is consumed and no pop occurs.
  - ARB: register sel and snapshot the head value of buffer sel (bits [2:1]) → REQ, with the timeout counter cleared.
  - REQ: pop_req=1 and pop_sel=sel. On pop_ack=1: read pulses, disp←sel, data_out←snapshot, last←sel → IDLE. If ACK_TIMEOUT cycles pass without ack: ack_err←1, no read pulse, last unchanged → IDLE.
- The reported value is the ARB snapshot even if the buffer changes before ack.
- pop_ack outside REQ is ignored.
- enable falling during ARB or REQ does not abort the transaction; it completes normally.
- rst at any cycle: state=IDLE, cnt=0, pending=0, last=3, and all outputs return to their reset values on the next edge.
- Reset values: pop_req=0, pop_sel=0, read=0, disp=0, data_out=0, missed_cnt=0, ack_err=0.

## Timing
- All outputs are registered.
- Tick at cycle T: IDLE at T+1 → ARB at T+2 → pop_req=1 visible from T+3.
- pop_ack sampled high at cycle A: at A+1, pop_req=0, read=1 for that one cycle, and disp/data_out are updated.
- Minimum tick-to-read latency is 4 cycles, given ack in the first REQ cycle.
- Timeout: pop_req drops after exactly ACK_TIMEOUT REQ cycles, and ack_err is set in the same cycle.
- pop_sel is stable for the whole time pop_req=1.
- A tick coincident with the IDLE that consumes pending counts as missed, because pending is still 1 when the tick arrives.

## Test plan
- READ_PERIOD=8, all buffers empty, enable=1 for 40 cycles → no pop_req, read never pulses, missed_cnt=0.
- buffer1 occ=2 with head value 2'b10, others empty, ack returned one cycle after req → pop_req with pop_sel=0, read pulse, disp=0, data_out=2'b10, 4 cycles after the tick.
- Occupancies {3,5,5,1} → first pop selects buffer2 (index 1). Same images on the next tick → selects index 2 (round-robin tie-break).
- pop_ack tied low, ACK_TIMEOUT=16 → pop_req high for 16 cycles then low, ack_err=1 stays set, no read pulse.
- READ_PERIOD=4, ack withheld 10 cycles → missed_cnt increments once per extra tick; force 300 extra ticks → missed_cnt holds at 255.
- Assert rst while in REQ → next cycle pop_req=0 and all outputs at reset values; first tie after reset goes to buffer1.
